// File: rtl/neuron_pkg.sv
// Shared sizing constants and controller state encoding for the threshold neuron.
package neuron_pkg;

  localparam int DATA_W = 8;
  localparam int THR_W  = 16;
  localparam int N_TAPS = 64;
  localparam int ACC_W  = 2*DATA_W + $clog2(N_TAPS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_THR = 3'd1,
    ACCUM    = 3'd2,
    DRAIN    = 3'd3,
    RESULT   = 3'd4
  } state_t;

endpackage

// File: rtl/mac_pipe.sv
// Two-stage multiply-accumulate: registered signed product, then accumulate with tap count.
module mac_pipe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 22,
  parameter int CNT_W  = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     tap_en,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic signed [DATA_W-1:0] weight_in,
  output logic                     prod_v,
  output logic [CNT_W-1:0]         tap_cnt,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = 2*DATA_W;

  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     prod_v_q, prod_v_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         tap_cnt_q, tap_cnt_d;

  always_comb begin
    prod_d    = prod_q;
    prod_v_d  = tap_en;
    acc_d     = acc_q;
    tap_cnt_d = tap_cnt_q;
    if (tap_en) begin
      prod_d = data_in * weight_in;
    end
    if (prod_v_q) begin
      acc_d     = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
      tap_cnt_d = tap_cnt_q + CNT_W'(1);
    end
    if (clr) begin
      prod_d    = '0;
      prod_v_d  = 1'b0;
      acc_d     = '0;
      tap_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q    <= '0;
      prod_v_q  <= 1'b0;
      acc_q     <= '0;
      tap_cnt_q <= '0;
    end else begin
      prod_q    <= prod_d;
      prod_v_q  <= prod_v_d;
      acc_q     <= acc_d;
      tap_cnt_q <= tap_cnt_d;
    end
  end

  assign prod_v  = prod_v_q;
  assign tap_cnt = tap_cnt_q;
  assign acc     = acc_q;

endmodule

// File: rtl/mac_threshold_unit.sv
// Threshold neuron: loads a 16-bit threshold in two beats, accumulates N_TAPS products,
// and reports the sum plus a compare-against-threshold result with a valid/ack handshake.
module mac_threshold_unit
  import neuron_pkg::*;
#(
  parameter int N_TAPS = neuron_pkg::N_TAPS,
  parameter int DATA_W = neuron_pkg::DATA_W,
  parameter int THR_W  = neuron_pkg::THR_W,
  localparam int ACC_W = 2*DATA_W + $clog2(N_TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rst_mem,
  input  logic                     mul_mem_en,
  input  logic                     ac_mem_en,
  input  logic                     threshold_ready,
  input  logic                     output_ready,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic signed [DATA_W-1:0] weight_in,
  input  logic [7:0]               thr_byte,
  input  logic                     out_ack,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     neuron_out,
  output logic                     out_valid,
  output logic                     overrun
);

  localparam int CNT_W = $clog2(N_TAPS) + 1;

  state_t                  state_q, state_d;
  logic [THR_W-1:0]        thr_q, thr_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic                    neuron_out_q, neuron_out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;

  logic                    prod_v;
  logic [CNT_W-1:0]        tap_cnt;
  logic signed [ACC_W-1:0] acc;
  logic                    tap_req, tap_room, tap_en;
  logic signed [ACC_W-1:0] thr_ext;

  // A tap still in the product stage already owns a slot, so it counts toward the limit.
  assign tap_req  = (state_q == ACCUM) && mul_mem_en && ac_mem_en;
  assign tap_room = (int'(tap_cnt) + int'(prod_v)) < N_TAPS;
  assign tap_en   = tap_req && tap_room && !rst_mem;
  assign thr_ext  = {{(ACC_W-THR_W){thr_q[THR_W-1]}}, thr_q};

  mac_pipe #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (rst_mem),
    .tap_en    (tap_en),
    .data_in   (data_in),
    .weight_in (weight_in),
    .prod_v    (prod_v),
    .tap_cnt   (tap_cnt),
    .acc       (acc)
  );

  always_comb begin
    state_d      = state_q;
    thr_d        = thr_q;
    acc_out_d    = acc_out_q;
    neuron_out_d = neuron_out_q;
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_q | (tap_req && !tap_room);
    unique case (state_q)
      IDLE: begin
        if (threshold_ready) begin
          thr_d   = THR_W'(thr_byte);
          state_d = LOAD_THR;
        end
      end
      LOAD_THR: begin
        thr_d   = {(threshold_ready ? thr_byte : 8'h00), thr_q[7:0]};
        state_d = ACCUM;
      end
      ACCUM: begin
        if (output_ready) state_d = DRAIN;
      end
      DRAIN: begin
        if (!prod_v) begin
          acc_out_d    = acc;
          neuron_out_d = (acc >= thr_ext);
          out_valid_d  = 1'b1;
          state_d      = RESULT;
        end
      end
      RESULT: begin
        if (out_ack) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_mem) begin
      state_d      = IDLE;
      thr_d        = '0;
      acc_out_d    = '0;
      neuron_out_d = 1'b0;
      out_valid_d  = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      thr_q        <= '0;
      acc_out_q    <= '0;
      neuron_out_q <= 1'b0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      thr_q        <= thr_d;
      acc_out_q    <= acc_out_d;
      neuron_out_q <= neuron_out_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign acc_out    = acc_out_q;
  assign neuron_out = neuron_out_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_mac_threshold_unit.sv
// Directed and randomized inferences checked against an arithmetic reference of the neuron.
module tb_mac_threshold_unit;
  import neuron_pkg::*;

  localparam int NT = 64;
  localparam int AW = 22;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rst_mem = 1'b0;
  logic              mul_mem_en = 1'b0;
  logic              ac_mem_en = 1'b0;
  logic              threshold_ready = 1'b0;
  logic              output_ready = 1'b0;
  logic signed [7:0] data_in = '0;
  logic signed [7:0] weight_in = '0;
  logic [7:0]        thr_byte = '0;
  logic              out_ack = 1'b0;
  logic signed [AW-1:0] acc_out;
  logic              neuron_out;
  logic              out_valid;
  logic              overrun;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  mac_threshold_unit #(.N_TAPS(NT), .DATA_W(8), .THR_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rst_mem         (rst_mem),
    .mul_mem_en      (mul_mem_en),
    .ac_mem_en       (ac_mem_en),
    .threshold_ready (threshold_ready),
    .output_ready    (output_ready),
    .data_in         (data_in),
    .weight_in       (weight_in),
    .thr_byte        (thr_byte),
    .out_ack         (out_ack),
    .acc_out         (acc_out),
    .neuron_out      (neuron_out),
    .out_valid       (out_valid),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_pulse();
    rst_mem = 1'b1;
    step();
    rst_mem = 1'b0;
  endtask

  task automatic load_thr(input logic [15:0] thr);
    threshold_ready = 1'b1;
    thr_byte = thr[7:0];
    step();
    thr_byte = thr[15:8];
    step();
    threshold_ready = 1'b0;
    thr_byte = '0;
  endtask

  // rnd=0: n back-to-back taps of d0*w0. rnd=1: random values and random non-tap gaps.
  task automatic run_inf(input string tag, input logic [15:0] thr, input int n, input bit rnd,
                         input logic signed [7:0] d0, input logic signed [7:0] w0);
    longint exp_sum = 0;
    int     taps = 0;
    longint thr_s = longint'($signed(thr));
    bit     got;
    clear_pulse();
    load_thr(thr);
    while (taps < n) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        int g = $urandom_range(0, 2);
        mul_mem_en = (g == 1);
        ac_mem_en  = (g == 2);
        data_in    = 8'($urandom);
        weight_in  = 8'($urandom);
      end else begin
        mul_mem_en = 1'b1;
        ac_mem_en  = 1'b1;
        data_in    = rnd ? 8'($urandom) : d0;
        weight_in  = rnd ? 8'($urandom) : w0;
        if (taps < NT) exp_sum += longint'(data_in) * longint'(weight_in);
        taps++;
      end
      step();
    end
    mul_mem_en = 1'b0;
    ac_mem_en  = 1'b0;
    check({tag, ".valid_before_req"}, longint'(out_valid), 0);
    output_ready = 1'b1;
    step();
    output_ready = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (out_valid) got = 1'b1;
      else step();
    end
    check({tag, ".valid_timeout"}, longint'(got), 1);
    check({tag, ".acc_out"}, longint'(acc_out), exp_sum);
    check({tag, ".neuron_out"}, longint'(neuron_out), (exp_sum >= thr_s) ? 1 : 0);
    check({tag, ".overrun"}, longint'(overrun), (taps > NT) ? 1 : 0);
    repeat (3) step();
    check({tag, ".valid_held"}, longint'(out_valid), 1);
    check({tag, ".acc_held"}, longint'(acc_out), exp_sum);
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    check({tag, ".valid_after_ack"}, longint'(out_valid), 0);
    check({tag, ".idle_after_ack"}, longint'(dut.state_q === IDLE), 1);
  endtask

  task automatic drive_taps(input int n);
    for (int i = 0; i < n; i++) begin
      mul_mem_en = 1'b1;
      ac_mem_en  = 1'b1;
      data_in    = 8'sd3;
      weight_in  = 8'sd5;
      step();
    end
  endtask

  initial begin
    #12;
    check("reset.acc_out", longint'(acc_out), 0);
    check("reset.valid", longint'(out_valid), 0);
    check("reset.overrun", longint'(overrun), 0);
    check("reset.neuron", longint'(neuron_out), 0);
    rst_n = 1'b1;
    step();

    run_inf("ones_thr64", 16'd64, 64, 1'b0, 8'sd1, 8'sd1);
    run_inf("ones_thr65", 16'd65, 64, 1'b0, 8'sd1, 8'sd1);
    run_inf("maxpos", 16'h7FFF, 64, 1'b0, -8'sd128, -8'sd128);
    run_inf("maxneg", 16'hFFFF, 64, 1'b0, -8'sd128, 8'sd127);
    run_inf("overrun65", 16'd0, 65, 1'b0, 8'sd1, 8'sd1);
    run_inf("partial10", 16'd9, 10, 1'b0, 8'sd1, 8'sd1);

    // Synchronous clear mid-accumulation, with a tap presented in the same cycle.
    clear_pulse();
    load_thr(16'd100);
    drive_taps(30);
    rst_mem = 1'b1;
    step();
    rst_mem = 1'b0;
    mul_mem_en = 1'b0;
    ac_mem_en  = 1'b0;
    check("rst_mem.acc", longint'(dut.u_pipe.acc), 0);
    check("rst_mem.tap_cnt", longint'(dut.u_pipe.tap_cnt), 0);
    check("rst_mem.state_idle", longint'(dut.state_q === IDLE), 1);
    check("rst_mem.valid", longint'(out_valid), 0);

    // Asynchronous reset mid-accumulation, asserted away from any clock edge.
    load_thr(16'd100);
    drive_taps(20);
    #2 rst_n = 1'b0;
    #1;
    check("rst_n.acc", longint'(dut.u_pipe.acc), 0);
    check("rst_n.prod_v", longint'(dut.u_pipe.prod_v), 0);
    check("rst_n.state_idle", longint'(dut.state_q === IDLE), 1);
    check("rst_n.valid", longint'(out_valid), 0);
    mul_mem_en = 1'b0;
    ac_mem_en  = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 6; k++) begin
      run_inf($sformatf("rand%0d", k), 16'($urandom), int'($urandom_range(1, 70)), 1'b1, 8'sd0, 8'sd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_threshold_unit.md
MAC_THRESHOLD_UNIT -- requirements
Module: mac_threshold_unit

Interface
REQ-001 SHALL have parameter N_TAPS, default 64: products accumulated per inference.
REQ-002 SHALL have parameter DATA_W, default 8: signed width of activation and weight.
REQ-003 SHALL have parameter THR_W, default 16: signed threshold width, loaded as two 8-bit beats.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port rst_mem, input, 1: synchronous one-cycle clear pulse from the control unit.
REQ-007 SHALL have port mul_mem_en, input, 1: multiply enable.
REQ-008 SHALL have port ac_mem_en, input, 1: accumulate enable.
REQ-009 SHALL have port threshold_ready, input, 1: threshold byte valid; high for 2 cycles.
REQ-010 SHALL have port output_ready, input, 1: result request from the control unit.
REQ-011 SHALL have port data_in, input, DATA_W: signed activation read at rd_data_ptr.
REQ-012 SHALL have port weight_in, input, DATA_W: signed weight read at rd_data_ptr.
REQ-013 SHALL have port thr_byte, input, 8: threshold byte, low byte first.
REQ-014 SHALL have port out_ack, input, 1: consumer accepts the result.
REQ-015 SHALL have port acc_out, output, ACC_W (=22): signed accumulated sum.
REQ-016 SHALL have port neuron_out, output, 1: 1 when acc_out >= sign-extended threshold.
REQ-017 SHALL have port out_valid, output, 1: result valid; held until out_ack.
REQ-018 SHALL have port overrun, output, 1: sticky flag; a tap arrived after N_TAPS.

Function
REQ-019 SHALL implement FSM IDLE -> LOAD_THR -> ACCUM -> DRAIN -> RESULT -> IDLE.
REQ-020 SHALL leave IDLE on threshold_ready=1: latch thr_byte as the low byte, beat=1, go to LOAD_THR.
REQ-021 SHALL in LOAD_THR with threshold_ready=1 latch the high byte and go to ACCUM; with threshold_ready=0 keep high byte 0x00 and go to ACCUM.
REQ-022 SHALL treat a tap as valid in a cycle where mul_mem_en && ac_mem_en; only in ACCUM.
REQ-023 SHALL use a 2-stage pipeline: stage 1 registers the signed product (prod_v); stage 2 adds it to the accumulator (acc += prod, 1 cycle after stage 1).
REQ-024 SHALL size ACC_W = 2*DATA_W + log2(N_TAPS) = 22 so the sum is exact with no saturation or wrap.
REQ-025 SHALL count accumulated taps in a 7-bit tap_cnt; taps arriving when tap_cnt+prod_v == N_TAPS SHALL be dropped and set overrun.
REQ-026 SHALL move ACCUM -> DRAIN on output_ready=1; DRAIN waits until prod_v=0 (pipeline empty), then goes to RESULT.
REQ-027 SHALL on entry to RESULT register acc_out and neuron_out and assert out_valid in that same cycle.
REQ-028 SHALL keep out_valid, acc_out and neuron_out stable until out_ack=1; then next cycle out_valid=0 and go to IDLE.
REQ-029 SHALL still produce a result if output_ready arrives with tap_cnt < N_TAPS (partial sum); no error flag for this case.
REQ-030 SHALL apply rst_mem in any state over any concurrent input: next cycle all registers equal their reset values.
REQ-031 SHALL ignore threshold_ready outside IDLE/LOAD_THR, and output_ready outside ACCUM.

Reset
REQ-032 SHALL on rst_n=0 immediately set state=IDLE, acc=0, prod=0, prod_v=0, tap_cnt=0, threshold=0, acc_out=0, neuron_out=0, out_valid=0, overrun=0.
REQ-033 SHALL on rst_mem set the same values synchronously, including overrun=0.

Structure
REQ-034 SHALL place DATA_W, THR_W, N_TAPS, ACC_W and the state enum in shared package neuron_pkg.
REQ-035 SHALL contain one sub-module mac_pipe: the product register, the accumulator and tap_cnt, with clear and enable inputs.

Verification
REQ-036 SHALL test: thr=64, 64 taps of data=1, weight=1 -> acc_out=64, neuron_out=1, out_valid until out_ack.
REQ-037 SHALL test: the same stimulus with thr=65 -> acc_out=64, neuron_out=0.
REQ-038 SHALL test: 64 taps of -128*-128, thr=0x7FFF -> acc_out=1048576, no wrap, neuron_out=1.
REQ-039 SHALL test: 64 taps of -128*127, thr=0xFFFF (-1) -> acc_out=-1040384, neuron_out=0.
REQ-040 SHALL test: rst_mem after tap 30 -> next cycle acc=0, state IDLE, out_valid=0; rst_n low asynchronously mid-ACCUM -> same values immediately.
REQ-041 SHALL test: 65 taps of 1*1 -> acc_out=64, overrun=1.
